// File: rtl/register_file_32.sv
// register_file_32: 2**ADDR_W x WIDTH register file with two combinational
// read ports and one clocked write port. Register 0 always reads as zero.
//
// Ports:
//   clk    - clock; writes happen on the rising edge
//   reset  - asynchronous, active-low; clears every register
//   we     - write enable
//   wa, wd - write address / write data
//   ra1    - read address, port 1; rd1 is its read data (combinational)
//   ra2    - read address, port 2; rd2 is its read data (combinational)
//
// Build option: define REGFILE_BYPASS_EN to forward wd to a read port whose
// address matches a pending non-zero write in the same cycle.
module register_file_32 #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2
);

   localparam int unsigned NREGS = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs [NREGS];

   // Write port; address 0 is never written so r0 stays zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // A live write to a non-zero address that is not held in reset.
   logic wr_live_c;
   assign wr_live_c = we && reset && (wa != '0);

   // Read port 1 with write-through forwarding.
   always_comb begin
      rd1 = regs[ra1];
      if (ra1 == '0) begin
         rd1 = '0;
      end else if (wr_live_c && (ra1 == wa)) begin
         rd1 = wd;
      end
   end

   // Read port 2 with write-through forwarding.
   always_comb begin
      rd2 = regs[ra2];
      if (ra2 == '0) begin
         rd2 = '0;
      end else if (wr_live_c && (ra2 == wa)) begin
         rd2 = wd;
      end
   end
`else
   // Read port 1 shows stored contents only.
   always_comb begin
      rd1 = regs[ra1];
      if (ra1 == '0) begin
         rd1 = '0;
      end
   end

   // Read port 2 shows stored contents only.
   always_comb begin
      rd2 = regs[ra2];
      if (ra2 == '0) begin
         rd2 = '0;
      end
   end
`endif

endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32: scoreboard bench for register_file_32. Stimulus pushes
// expected read data into queues and raises a sample event; a monitor process
// pops the queues and compares against rd1/rd2.
module tb_register_file_32;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned HALF   = 10;

   logic              clk;
   logic              reset;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [WIDTH-1:0]  wd;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [WIDTH-1:0]  rd1;
   logic [WIDTH-1:0]  rd2;

   int total;
   int bad;

   string            name_q [$];
   logic [WIDTH-1:0] e1_q   [$];
   logic [WIDTH-1:0] e2_q   [$];
   bit               use2_q [$];
   event             chk_ev;

   register_file_32 #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   initial clk = 1'b0;
   always #(HALF) clk = ~clk;

   // Queue an expectation and ask the monitor to sample now.
   task automatic check(input string n, input logic [WIDTH-1:0] e1,
                        input logic [WIDTH-1:0] e2, input bit u2);
      name_q.push_back(n);
      e1_q.push_back(e1);
      e2_q.push_back(e2);
      use2_q.push_back(u2);
      ->chk_ev;
      #1;
   endtask

   // One clocked write; returns 1 time unit after the rising edge with we=0.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      we = 1'b1;
      wa = a;
      wd = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   // Monitor: compare DUT read data against every queued expectation.
   initial begin
      forever begin
         @(chk_ev);
         while (e1_q.size() > 0) begin
            string            n;
            logic [WIDTH-1:0] e1;
            logic [WIDTH-1:0] e2;
            bit               u2;
            n  = name_q.pop_front();
            e1 = e1_q.pop_front();
            e2 = e2_q.pop_front();
            u2 = use2_q.pop_front();
            total++;
            if (rd1 !== e1) begin
               bad++;
               $display("FAIL %s rd1: got %h expected %h", n, rd1, e1);
            end
            if (u2) begin
               total++;
               if (rd2 !== e2) begin
                  bad++;
                  $display("FAIL %s rd2: got %h expected %h", n, rd2, e2);
               end
            end
         end
      end
   end

   logic [WIDTH-1:0] same_exp;
   logic [WIDTH-1:0] fall_exp;

   initial begin
      total = 0;
      bad   = 0;
`ifdef REGFILE_BYPASS_EN
      same_exp = 32'd20;
      fall_exp = 32'd1;
`else
      same_exp = 32'd10;
      fall_exp = 32'h12345678;
`endif

      // Reset: reads are zero; a write during reset is ignored.
      reset = 1'b0;
      we    = 1'b1;
      wa    = 5'd5;
      wd    = 32'd7;
      ra1   = 5'd5;
      ra2   = 5'd31;
      #5;
      check("reset_read", 32'd0, 32'd0, 1'b1);
      #9;
      reset = 1'b1;
      we    = 1'b0;
      #1;
      check("write_in_reset", 32'd0, 32'd0, 1'b1);

      // Basic write/read, then we=0 leaves contents alone.
      do_write(5'd3, 32'd52);
      ra1 = 5'd3;
      check("basic_write", 32'd52, 32'd0, 1'b0);
      we = 1'b0;
      wa = 5'd3;
      wd = 32'd99;
      @(posedge clk);
      #1;
      check("we_low_hold", 32'd52, 32'd0, 1'b0);

      // Register zero: never written, never forwarded.
      we  = 1'b1;
      wa  = 5'd0;
      wd  = 32'hFFFFFFFF;
      ra1 = 5'd0;
      ra2 = 5'd0;
      check("r0_pre_edge", 32'd0, 32'd0, 1'b1);
      @(posedge clk);
      #1;
      we = 1'b0;
      check("r0_post_edge", 32'd0, 32'd0, 1'b1);

      // Dual port reads of two different registers.
      do_write(5'd7, 32'h12345678);
      do_write(5'd8, 32'hDEADBEEF);
      ra1 = 5'd7;
      ra2 = 5'd8;
      check("dual_port", 32'h12345678, 32'hDEADBEEF, 1'b1);

      // Falling edge with we=1 must not write.
      we = 1'b1;
      wa = 5'd7;
      wd = 32'd1;
      @(negedge clk);
      #1;
      check("fall_edge_live", fall_exp, 32'hDEADBEEF, 1'b1);
      we = 1'b0;
      check("fall_edge_nowrite", 32'h12345678, 32'hDEADBEEF, 1'b1);
      we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      check("rise_after_fall", 32'd1, 32'hDEADBEEF, 1'b1);

      // Highest address.
      do_write(5'd31, 32'hA5A5A5A5);
      ra2 = 5'd31;
      check("top_addr", 32'd1, 32'hA5A5A5A5, 1'b1);

      // Same-cycle read of the address being written; both ports agree.
      do_write(5'd9, 32'd10);
      we  = 1'b1;
      wa  = 5'd9;
      wd  = 32'd20;
      ra1 = 5'd9;
      ra2 = 5'd9;
      check("same_cycle_pre", same_exp, same_exp, 1'b1);
      @(posedge clk);
      #1;
      we = 1'b0;
      check("same_cycle_post", 32'd20, 32'd20, 1'b1);

      // Asynchronous reset mid-period clears everything.
      do_write(5'd4, 32'h55);
      ra1 = 5'd4;
      ra2 = 5'd9;
      check("pre_mid_reset", 32'h55, 32'd20, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset", 32'd0, 32'd0, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      ra1 = 5'd3;
      ra2 = 5'd31;
      check("after_mid_reset", 32'd0, 32'd0, 1'b1);

      #2;
      if (e1_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", e1_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
